// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide dispatch stage: op encoding,
// op width and the packed request record carried through the FIFO.
package md_pkg;

  localparam int MD_OP_W = 3;

  typedef enum logic [MD_OP_W-1:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5,
    MD_MSUB  = 3'd6
  } md_op_e;

  typedef struct packed {
    logic [MD_OP_W-1:0] op;
    logic [31:0]        a;
    logic [31:0]        b;
  } md_req_t;

  localparam int MD_REQ_W = $bits(md_req_t);

endpackage

// File: rtl/md_fifo.sv
// Circular request buffer for md_dispatch: storage, wrapping pointers,
// occupancy count and a synchronous flush that discards every entry.
module md_fifo
  import md_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      push,
  input  logic                      pop,
  input  logic                      flush,
  input  logic [MD_REQ_W-1:0]       din,
  output logic [MD_REQ_W-1:0]       head,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int AW = $clog2(DEPTH);

  logic [MD_REQ_W-1:0] mem [DEPTH];
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;

  // Payload storage needs no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/md_dispatch.sv
// Dispatch stage in front of the HI/LO multiply/divide unit: buffers EX requests,
// issues one-cycle start pulses and stalls mfhi/mflo. Option: MD_DISPATCH_BYPASS_EN.
module md_dispatch
  import md_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [2:0]             req_op,
  input  logic [31:0]            req_a,
  input  logic [31:0]            req_b,
  input  logic                   flush,
  input  logic                   rd_hilo,
  output logic                   stall,
  output logic                   xalu_start,
  output logic [2:0]             xalu_op,
  output logic [31:0]            xalu_a,
  output logic [31:0]            xalu_b,
  input  logic                   xalu_busy,
  output logic [$clog2(DEPTH):0] pending
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [CW-1:0] count;
  logic          accept;
  logic          unit_free;
  logic          issue;
  logic          bypass;
  logic          push;
  md_req_t       req;
  md_req_t       head;

  assign req       = '{op: req_op, a: req_a, b: req_b};
  assign req_ready = (count != FULL_CNT);
  assign accept    = req_valid && req_ready;
  // The unit's busy flag lags start by one edge, so a live pulse also blocks issue.
  assign unit_free = !xalu_busy && !xalu_start && !flush;
  assign issue     = (count != '0) && unit_free;

`ifdef MD_DISPATCH_BYPASS_EN
  assign bypass = accept && (count == '0) && unit_free;
`else
  assign bypass = 1'b0;
`endif

  assign push = accept && !bypass;

  md_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (issue),
    .flush (flush),
    .din   (req),
    .head  (head),
    .count (count)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      xalu_start <= 1'b0;
      xalu_op    <= '0;
      xalu_a     <= '0;
      xalu_b     <= '0;
    end else begin
      xalu_start <= issue || bypass;
      if (issue) begin
        xalu_op <= head.op;
        xalu_a  <= head.a;
        xalu_b  <= head.b;
      end else if (bypass) begin
        xalu_op <= req.op;
        xalu_a  <= req.a;
        xalu_b  <= req.b;
      end
    end
  end

  assign stall   = rd_hilo && ((count != '0) || xalu_start || xalu_busy);
  assign pending = count;

endmodule

// File: tb/tb_md_dispatch.sv
// Directed table-driven bench for md_dispatch (DEPTH=2) plus hand-written
// sequences for asynchronous reset mid-issue and the optional bypass path.
module tb_md_dispatch;
  import md_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = '0;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic        flush = 1'b0;
  logic        rd_hilo = 1'b0;
  logic        stall;
  logic        xalu_start;
  logic [2:0]  xalu_op;
  logic [31:0] xalu_a;
  logic [31:0] xalu_b;
  logic        xalu_busy = 1'b0;
  logic [1:0]  pending;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  md_dispatch #(.DEPTH(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .flush      (flush),
    .rd_hilo    (rd_hilo),
    .stall      (stall),
    .xalu_start (xalu_start),
    .xalu_op    (xalu_op),
    .xalu_a     (xalu_a),
    .xalu_b     (xalu_b),
    .xalu_busy  (xalu_busy),
    .pending    (pending)
  );

  typedef struct {
    logic        v;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        rd;
    logic        busy;
    logic        fl;
    logic        e_ready;
    logic        e_stall;
    logic        e_start;
    logic [2:0]  e_op;
    logic [31:0] e_a;
    logic [31:0] e_b;
    logic [1:0]  e_pend;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic v, logic [2:0] op, logic [31:0] a, logic [31:0] b,
                              logic rd, logic busy, logic fl,
                              logic e_ready, logic e_stall, logic e_start,
                              logic [2:0] e_op, logic [31:0] e_a, logic [31:0] e_b,
                              logic [1:0] e_pend);
    vec_t r;
    r.v = v; r.op = op; r.a = a; r.b = b; r.rd = rd; r.busy = busy; r.fl = fl;
    r.e_ready = e_ready; r.e_stall = e_stall; r.e_start = e_start;
    r.e_op = e_op; r.e_a = e_a; r.e_b = e_b; r.e_pend = e_pend;
    return r;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(vec_t r);
    req_valid = r.v;
    req_op    = r.op;
    req_a     = r.a;
    req_b     = r.b;
    rd_hilo   = r.rd;
    xalu_busy = r.busy;
    flush     = r.fl;
  endtask

  task automatic checkOutput(int i, vec_t r);
    chk($sformatf("row%0d req_ready", i), {31'd0, req_ready}, {31'd0, r.e_ready});
    chk($sformatf("row%0d stall", i), {31'd0, stall}, {31'd0, r.e_stall});
    chk($sformatf("row%0d xalu_start", i), {31'd0, xalu_start}, {31'd0, r.e_start});
    chk($sformatf("row%0d xalu_op", i), {29'd0, xalu_op}, {29'd0, r.e_op});
    chk($sformatf("row%0d xalu_a", i), xalu_a, r.e_a);
    chk($sformatf("row%0d xalu_b", i), xalu_b, r.e_b);
    chk($sformatf("row%0d pending", i), {30'd0, pending}, {30'd0, r.e_pend});
  endtask

  initial begin
    // Inputs: v op a b rd busy flush | expected: ready stall start op a b pending
    vecs.push_back(mk(0,0,0,0,                 0,0,0, 1,0,0, 0,0,0,0));
    vecs.push_back(mk(1,0,3,32'hFFFFFFFE,      0,0,0, 1,0,0, 0,0,0,0));
    vecs.push_back(mk(0,0,0,0,                 0,0,0, 1,0,0, 0,0,0,1));
    vecs.push_back(mk(0,0,0,0,                 0,0,0, 1,0,1, 0,3,32'hFFFFFFFE,0));
    vecs.push_back(mk(0,0,0,0,                 1,1,0, 1,1,0, 0,3,32'hFFFFFFFE,0));
    vecs.push_back(mk(1,2,100,7,               0,1,0, 1,0,0, 0,3,32'hFFFFFFFE,0));
    vecs.push_back(mk(1,3,200,9,               0,1,0, 1,0,0, 0,3,32'hFFFFFFFE,1));
    vecs.push_back(mk(1,0,5,6,                 0,1,0, 0,0,0, 0,3,32'hFFFFFFFE,2));
    vecs.push_back(mk(1,0,5,6,                 0,1,0, 0,0,0, 0,3,32'hFFFFFFFE,2));
    vecs.push_back(mk(1,0,5,6,                 0,0,0, 0,0,0, 0,3,32'hFFFFFFFE,2));
    vecs.push_back(mk(1,0,5,6,                 0,0,0, 1,0,1, 2,100,7,1));
    vecs.push_back(mk(0,0,0,0,                 0,1,0, 0,0,0, 2,100,7,2));
    vecs.push_back(mk(0,0,0,0,                 0,1,0, 0,0,0, 2,100,7,2));
    vecs.push_back(mk(0,0,0,0,                 0,0,0, 0,0,0, 2,100,7,2));
    vecs.push_back(mk(0,0,0,0,                 1,0,0, 1,1,1, 3,200,9,1));
    vecs.push_back(mk(0,0,0,0,                 1,1,0, 1,1,0, 3,200,9,1));
    vecs.push_back(mk(0,0,0,0,                 1,0,0, 1,1,0, 3,200,9,1));
    vecs.push_back(mk(0,0,0,0,                 1,0,0, 1,1,1, 0,5,6,0));
    vecs.push_back(mk(0,0,0,0,                 1,1,0, 1,1,0, 0,5,6,0));
    vecs.push_back(mk(0,0,0,0,                 1,0,0, 1,0,0, 0,5,6,0));
    vecs.push_back(mk(1,0,1,1,                 0,1,0, 1,0,0, 0,5,6,0));
    vecs.push_back(mk(1,6,2,2,                 0,1,0, 1,0,0, 0,5,6,1));
    vecs.push_back(mk(0,0,0,0,                 0,1,1, 0,0,0, 0,5,6,2));
    vecs.push_back(mk(0,0,0,0,                 0,1,0, 1,0,0, 0,5,6,0));
    vecs.push_back(mk(0,0,0,0,                 0,0,0, 1,0,0, 0,5,6,0));
    vecs.push_back(mk(0,0,0,0,                 0,0,0, 1,0,0, 0,5,6,0));
    vecs.push_back(mk(1,7,32'h77,32'h88,       0,0,0, 1,0,0, 0,5,6,0));
    vecs.push_back(mk(0,0,0,0,                 0,0,1, 1,0,0, 0,5,6,1));
    vecs.push_back(mk(0,0,0,0,                 0,0,0, 1,0,0, 0,5,6,0));
    vecs.push_back(mk(1,7,32'h77,32'h88,       0,0,0, 1,0,0, 0,5,6,0));
    vecs.push_back(mk(0,0,0,0,                 0,0,0, 1,0,0, 0,5,6,1));
    vecs.push_back(mk(0,0,0,0,                 0,0,0, 1,0,1, 7,32'h77,32'h88,0));
    vecs.push_back(mk(1,0,9,9,                 0,0,1, 1,0,0, 7,32'h77,32'h88,0));
    vecs.push_back(mk(0,0,0,0,                 0,0,0, 1,0,0, 7,32'h77,32'h88,0));
    vecs.push_back(mk(1,0,10,11,               0,1,0, 1,0,0, 7,32'h77,32'h88,0));
    vecs.push_back(mk(1,1,12,13,               0,1,0, 1,0,0, 7,32'h77,32'h88,1));
    vecs.push_back(mk(1,4,14,0,                0,0,0, 0,0,0, 7,32'h77,32'h88,2));
    vecs.push_back(mk(1,4,14,0,                0,0,0, 1,0,1, 0,10,11,1));
    vecs.push_back(mk(0,0,0,0,                 0,1,0, 0,0,0, 0,10,11,2));
    vecs.push_back(mk(0,0,0,0,                 0,0,0, 0,0,0, 0,10,11,2));
    vecs.push_back(mk(0,0,0,0,                 0,0,0, 1,0,1, 1,12,13,1));
    vecs.push_back(mk(0,0,0,0,                 0,1,0, 1,0,0, 1,12,13,1));
    vecs.push_back(mk(0,0,0,0,                 0,0,0, 1,0,0, 1,12,13,1));
    vecs.push_back(mk(0,0,0,0,                 0,0,0, 1,0,1, 4,14,0,0));

    repeat (2) @(posedge clk);
    #1;
    chk("reset start", {31'd0, xalu_start}, 32'd0);
    chk("reset pending", {30'd0, pending}, 32'd0);
    chk("reset ready", {31'd0, req_ready}, 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;

`ifndef MD_DISPATCH_BYPASS_EN
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      #1;
      checkOutput(i, vecs[i]);
      @(posedge clk);
      #1;
    end
`endif

    // Fill two entries, issue one, then pull reset while the start pulse is live.
    req_valid = 1'b1; req_op = MD_MULT; req_a = 32'h21; req_b = 32'h0;
    xalu_busy = 1'b1; rd_hilo = 1'b0; flush = 1'b0;
    @(posedge clk); #1;
    req_a = 32'h22;
    @(posedge clk); #1;
    req_valid = 1'b0; xalu_busy = 1'b0;
    @(posedge clk); #1;
    chk("pre-reset start", {31'd0, xalu_start}, 32'd1);
    chk("pre-reset op", {29'd0, xalu_op}, 32'd0);
    chk("pre-reset a", xalu_a, 32'h21);
    chk("pre-reset pending", {30'd0, pending}, 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("async reset start", {31'd0, xalu_start}, 32'd0);
    chk("async reset a", xalu_a, 32'd0);
    chk("async reset pending", {30'd0, pending}, 32'd0);
    chk("async reset ready", {31'd0, req_ready}, 32'd1);
    rd_hilo = 1'b1;
    #1;
    chk("async reset stall", {31'd0, stall}, 32'd0);
    #1 reset = 1'b1;
    rd_hilo = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk($sformatf("post-reset start%0d", k), {31'd0, xalu_start}, 32'd0);
      chk($sformatf("post-reset pending%0d", k), {30'd0, pending}, 32'd0);
    end

`ifdef MD_DISPATCH_BYPASS_EN
    req_valid = 1'b1; req_op = MD_MULT; req_a = 32'd3; req_b = 32'hFFFFFFFE;
    #1;
    chk("bypass pre start", {31'd0, xalu_start}, 32'd0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("bypass start", {31'd0, xalu_start}, 32'd1);
    chk("bypass op", {29'd0, xalu_op}, 32'd0);
    chk("bypass a", xalu_a, 32'd3);
    chk("bypass b", xalu_b, 32'hFFFFFFFE);
    chk("bypass pending", {30'd0, pending}, 32'd0);
    @(posedge clk); #1;
    chk("bypass start drop", {31'd0, xalu_start}, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
